pixel_peak_capture: RTL and testbench

- Downstream neighbour of the serial sample controller; consumes its SI frame-start pulse (serial_out) plus the ADC pixel stream of the linear optical sensor.
- Frames NUM_PIXELS samples per SI pulse and tracks the brightest pixel (light-spot position, i.e. force deflection).
- Presents one result per frame to the host/UART stage over a valid/ready handshake.

---
 rtl/pixel_capture_pkg.sv | 13 +
 rtl/si_edge_detect.sv | 26 ++
 rtl/pixel_peak_capture.sv | 182 ++++++++++++++++++
 tb/tb_pixel_peak_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_capture_pkg.sv
// Shared types and default sizes for the pixel peak capture stages.
package pixel_capture_pkg;

   localparam int NUM_PIXELS_DEF = 128;
   localparam int ADC_W_DEF      = 12;
   localparam int IDX_W_DEF      = 7;

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } cap_state_e;

endpackage

// File: rtl/si_edge_detect.sv
// Registers the SI level and flags its rising edge in the same cycle the high level is sampled.
module si_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic si_in,
   output logic si_rise
);

   logic si_q;
   logic si_d;

   always_comb begin
      si_d = si_in;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         si_q <= 1'b0;
      end else begin
         si_q <= si_d;
      end
   end

   assign si_rise = si_in & ~si_q;

endmodule

// File: rtl/pixel_peak_capture.sv
// Frames NUM_PIXELS ADC samples per SI pulse and reports the brightest pixel over valid/ready.
// Define PIXEL_SUM_EN to add the pix_sum output (sum of all samples in the frame).
module pixel_peak_capture
   import pixel_capture_pkg::*;
#(
   parameter int NUM_PIXELS = NUM_PIXELS_DEF,
   parameter int ADC_W      = ADC_W_DEF,
   parameter int IDX_W      = IDX_W_DEF
) (
   input  logic             sensor_clk,
   input  logic             reset,
   input  logic             si_in,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] adc_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [IDX_W-1:0] peak_idx,
   output logic [ADC_W-1:0] peak_val,
   output logic             frame_short,
`ifdef PIXEL_SUM_EN
   output logic [ADC_W+IDX_W-1:0] pix_sum,
`endif
   output logic             overrun
);

   localparam int CNT_W = IDX_W + 1;
   localparam int SUM_W = ADC_W + IDX_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic si_rise;

   si_edge_detect u_si_edge (
      .clk     (sensor_clk),
      .reset   (reset),
      .si_in   (si_in),
      .si_rise (si_rise)
   );

   cap_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADC_W-1:0] max_q, max_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             res_valid_q, res_valid_d;
   logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
   logic [ADC_W-1:0] peak_val_q, peak_val_d;
   logic             short_q, short_d;
   logic             overrun_q, overrun_d;

   logic             commit;
   logic             commit_short;
   logic [IDX_W-1:0] commit_idx;
   logic [ADC_W-1:0] commit_val;
   logic             take;

   // A sample is taken on any valid cycle that either starts a frame or lands inside one.
   assign take = adc_valid & (si_rise | (state_q == CAPTURE));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      max_d        = max_q;
      idx_d        = idx_q;
      commit       = 1'b0;
      commit_short = 1'b0;
      commit_idx   = idx_q;
      commit_val   = max_q;

      if (si_rise) begin
         if (state_q == CAPTURE && cnt_q != '0) begin
            commit       = 1'b1;
            commit_short = 1'b1;
         end
         state_d = CAPTURE;
         cnt_d   = '0;
         max_d   = '0;
         idx_d   = '0;
         if (adc_valid) begin
            cnt_d = CNT_W'(1);
            max_d = adc_data;
         end
      end else if (state_q == CAPTURE && adc_valid) begin
         // Strictly-greater update keeps the lowest index on ties.
         if (adc_data > max_q) begin
            max_d = adc_data;
            idx_d = cnt_q[IDX_W-1:0];
         end
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (cnt_q == LAST_CNT) begin
            commit     = 1'b1;
            commit_idx = idx_d;
            commit_val = max_d;
            state_d    = IDLE;
         end
      end
   end

   always_comb begin
      res_valid_d = res_valid_q;
      peak_idx_d  = peak_idx_q;
      peak_val_d  = peak_val_q;
      short_d     = short_q;
      overrun_d   = overrun_q;

      if (commit) begin
         res_valid_d = 1'b1;
         peak_idx_d  = commit_idx;
         peak_val_d  = commit_val;
         short_d     = commit_short;
         if (res_valid_q && !res_ready) begin
            overrun_d = 1'b1;
         end
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge sensor_clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         max_q       <= '0;
         idx_q       <= '0;
         res_valid_q <= 1'b0;
         peak_idx_q  <= '0;
         peak_val_q  <= '0;
         short_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         idx_q       <= idx_d;
         res_valid_q <= res_valid_d;
         peak_idx_q  <= peak_idx_d;
         peak_val_q  <= peak_val_d;
         short_q     <= short_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef PIXEL_SUM_EN
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] pix_sum_q, pix_sum_d;

   // A short commit reports the frame so far; a full commit includes the final sample.
   always_comb begin
      sum_d     = sum_q;
      pix_sum_d = pix_sum_q;
      if (si_rise) begin
         sum_d = adc_valid ? SUM_W'(adc_data) : '0;
      end else if (take) begin
         sum_d = sum_q + SUM_W'(adc_data);
      end
      if (commit) begin
         pix_sum_d = commit_short ? sum_q : sum_d;
      end
   end

   always_ff @(posedge sensor_clk) begin
      if (!reset) begin
         sum_q     <= '0;
         pix_sum_q <= '0;
      end else begin
         sum_q     <= sum_d;
         pix_sum_q <= pix_sum_d;
      end
   end

   assign pix_sum = pix_sum_q;
`endif

   assign res_valid   = res_valid_q;
   assign peak_idx    = peak_idx_q;
   assign peak_val    = peak_val_q;
   assign frame_short = short_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_pixel_peak_capture.sv
// Randomized scoreboard bench for pixel_peak_capture against a frame-level reference model.
module tb_pixel_peak_capture;

   localparam int NP = 128;
   localparam int AW = 12;
   localparam int IW = 7;
   localparam int SW = AW + IW;

   logic          sensor_clk = 1'b0;
   logic          reset = 1'b0;
   logic          si_in = 1'b0;
   logic          adc_valid = 1'b0;
   logic [AW-1:0] adc_data = '0;
   logic          res_valid;
   logic          res_ready = 1'b1;
   logic [IW-1:0] peak_idx;
   logic [AW-1:0] peak_val;
   logic          frame_short;
   logic          overrun;
   logic [SW-1:0] pix_sum;

   pixel_peak_capture #(.NUM_PIXELS(NP), .ADC_W(AW), .IDX_W(IW)) dut (
      .sensor_clk  (sensor_clk),
      .reset       (reset),
      .si_in       (si_in),
      .adc_valid   (adc_valid),
      .adc_data    (adc_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .peak_idx    (peak_idx),
      .peak_val    (peak_val),
      .frame_short (frame_short),
`ifdef PIXEL_SUM_EN
      .pix_sum     (pix_sum),
`endif
      .overrun     (overrun)
   );

   always #5 sensor_clk = ~sensor_clk;

   typedef struct {
      logic [IW-1:0] idx;
      logic [AW-1:0] val;
      logic          short_f;
      logic [SW-1:0] sum;
   } res_t;

   res_t          exp_q[$];
   logic [AW-1:0] frame[$];
   logic [AW-1:0] stim[$];
   bit            in_frame = 0;
   bit            si_prev  = 0;
   bit            exp_ovr  = 0;
   bit            started  = 0;
   int            n_chk    = 0;
   int            n_fail   = 0;

`ifndef PIXEL_SUM_EN
   assign pix_sum = '0;
`endif

   function automatic res_t summarize(input bit short_f);
      res_t r;
      r.idx = '0; r.val = '0; r.sum = '0; r.short_f = short_f;
      foreach (frame[i]) begin
         if (frame[i] > r.val) begin
            r.val = frame[i];
            r.idx = IW'(i);
         end
         r.sum = r.sum + SW'(frame[i]);
      end
      return r;
   endfunction

   // An unconsumed entry still queued at commit time was never accepted, so it is lost.
   task automatic commit_model(input res_t r);
      if (exp_q.size() != 0) begin
         void'(exp_q.pop_back());
         exp_ovr = 1;
      end
      exp_q.push_back(r);
   endtask

   task automatic model_step(input bit si, input bit v, input logic [AW-1:0] d);
      bit rise;
      rise = si & ~si_prev;
      si_prev = si;
      if (rise) begin
         if (in_frame && frame.size() > 0) commit_model(summarize(1));
         frame.delete();
         in_frame = 1;
         if (v) frame.push_back(d);
      end else if (in_frame && v) begin
         frame.push_back(d);
         if (frame.size() == NP) begin
            commit_model(summarize(0));
            in_frame = 0;
         end
      end
   endtask

   task automatic cyc(input bit si, input bit v, input logic [AW-1:0] d);
      si_in = si; adc_valid = v; adc_data = d;
      @(posedge sensor_clk);
      if (reset) model_step(si, v, d);
      else begin
         exp_q.delete(); frame.delete();
         in_frame = 0; si_prev = 0; exp_ovr = 0;
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) cyc(0, 0, '0);
      reset = 1'b1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic play(input bit gaps);
      for (int i = 0; i < stim.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) cyc(0, 0, AW'($urandom));
         cyc(0, 1, stim[i]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, '0);
   endtask

   always @(negedge sensor_clk) begin
      if (started) begin
         n_chk++;
         if (res_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL res_valid: got %b expected %0d", res_valid, exp_q.size() != 0);
         end
         n_chk++;
         if (overrun !== exp_ovr) begin
            n_fail++;
            $display("FAIL overrun: got %b expected %0d", overrun, exp_ovr);
         end
         if (exp_q.size() != 0) begin
            n_chk++;
            if (peak_idx !== exp_q[0].idx || peak_val !== exp_q[0].val ||
                frame_short !== exp_q[0].short_f
`ifdef PIXEL_SUM_EN
                || pix_sum !== exp_q[0].sum
`endif
               ) begin
               n_fail++;
               $display("FAIL result: got idx=%0d val=%0d short=%b sum=%0d expected idx=%0d val=%0d short=%b sum=%0d",
                        peak_idx, peak_val, frame_short, pix_sum,
                        exp_q[0].idx, exp_q[0].val, exp_q[0].short_f, exp_q[0].sum);
            end
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      do_reset(2);
      started = 1;
      chk("rst_valid", res_valid, 0);
      chk("rst_idx", peak_idx, 0);
      chk("rst_val", peak_val, 0);
      chk("rst_short", frame_short, 0);
      chk("rst_ovr", overrun, 0);

      // Full frame, peak 4000 at pixel 37.
      stim.delete();
      for (int i = 0; i < NP; i++) stim.push_back(AW'(i == 37 ? 4000 : 10 * (i + 1)));
      cyc(1, 0, '0);
      play(1);
      chk("lat_valid", res_valid, 1);
      chk("f1_idx", peak_idx, 37);
      chk("f1_val", peak_val, 4000);
      chk("f1_short", frame_short, 0);
      idle(3);

      // Tie at 3000: lowest index wins.
      stim.delete();
      for (int i = 0; i < NP; i++)
         stim.push_back((i == 5 || i == 90) ? AW'(3000) : AW'($urandom_range(0, 2999)));
      cyc(1, 0, '0);
      play(1);
      chk("tie_idx", peak_idx, 5);
      chk("tie_val", peak_val, 3000);
      idle(3);

      // Early SI after 50 samples, coincident sample becomes pixel 0.
      stim.delete();
      for (int i = 0; i < 50; i++)
         stim.push_back(i == 12 ? AW'(2500) : AW'($urandom_range(0, 2499)));
      cyc(1, 0, '0);
      play(0);
      cyc(1, 1, AW'(777));
      chk("short_idx", peak_idx, 12);
      chk("short_val", peak_val, 2500);
      chk("short_flag", frame_short, 1);
      stim.delete();
      for (int i = 1; i < NP; i++) stim.push_back(AW'($urandom_range(0, 700)));
      play(0);
      chk("restart_idx", peak_idx, 0);
      chk("restart_val", peak_val, 777);
      idle(3);

      // Two frames with no consumer: overwrite and sticky overrun.
      res_ready = 1'b0;
      repeat (2) begin
         stim.delete();
         for (int i = 0; i < NP; i++) stim.push_back(AW'($urandom));
         cyc(1, 0, '0);
         play(1);
         idle(2);
      end
      chk("ovr_set", overrun, 1);
      res_ready = 1'b1;
      cyc(0, 0, '0);
      chk("ovr_drop_valid", res_valid, 0);
      chk("ovr_sticky", overrun, 1);
      idle(3);

      // Reset at pixel 64, then samples without SI are ignored.
      stim.delete();
      for (int i = 0; i < 64; i++) stim.push_back(AW'($urandom));
      cyc(1, 0, '0);
      play(0);
      do_reset(1);
      for (int i = 0; i < 20; i++) cyc(0, 1, AW'($urandom));
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_idx", peak_idx, 0);
      chk("mid_rst_val", peak_val, 0);
      chk("mid_rst_ovr", overrun, 0);

      // Saturated frame and all-zero frame.
      stim.delete();
      for (int i = 0; i < NP; i++) stim.push_back(AW'(4095));
      cyc(1, 0, '0);
      play(0);
      chk("sat_val", peak_val, 4095);
      chk("sat_idx", peak_idx, 0);
`ifdef PIXEL_SUM_EN
      chk("sat_sum", pix_sum, 524160);
`endif
      idle(2);
      stim.delete();
      for (int i = 0; i < NP; i++) stim.push_back('0);
      cyc(1, 0, '0);
      play(1);
      chk("zero_val", peak_val, 0);
      chk("zero_idx", peak_idx, 0);
`ifdef PIXEL_SUM_EN
      chk("zero_sum", pix_sum, 0);
`endif
      idle(2);

      // Random traffic: sparse SI pulses, random valid and ready, tie-prone data.
      for (int i = 0; i < 6000; i++) begin
         logic [AW-1:0] d;
         res_ready = ($urandom_range(0, 3) != 0);
         d = ((i / 500) % 2 == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, d);
      end
      cyc(0, 0, '0);

      res_ready = 1'b1;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(0, 0, '0);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
